// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction formats, encoder states,
// NOP and opcode constants, and the field-to-word packing function.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // Packs one field set into a 32-bit word; the two unused format codes become NOP.
  function automatic logic [31:0] encode_inst(
    input logic [2:0]  fmt,
    input logic [6:0]  opcode,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] word;
    word = NOP;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = NOP;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Output buffer for encoded words tagged with their address. Accepts a push
// while full as long as a pop happens in the same cycle.
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the data outputs read zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes a stream of RISC-V field sets into address-tagged instruction words.
// Optional ENCODER_RANGE_CHECK_EN adds a sticky err flag for out-of-range immediates.
module instruction_encoder #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
`ifdef ENCODER_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);

  import riscv_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e              state_q;
  state_e              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         remain_q;
  logic                done_zero_q;
  logic                start_ok;
  logic                in_xfer;
  logic                pop;
  logic                last_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [31+ADDR_W:0]  push_data;
  logic [31+ADDR_W:0]  pop_data;

  assign start_ok  = start && (state_q == IDLE);
  assign in_ready  = (state_q == LOAD) && !fifo_full;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign last_pop  = (state_q == DRAIN) && pop && (fifo_count == CNT_W'(1));
  assign busy      = (state_q != IDLE);
  assign done      = done_zero_q || last_pop;
  assign push_data = {addr_q, encode_inst(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm)};
  assign out_inst  = pop_data[31:0];
  assign out_addr  = pop_data[31+ADDR_W:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Everything pushed before DRAIN, so the single remaining entry is the final word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && prog_len != 16'd0) state_d = LOAD;
      LOAD:    if (in_xfer && remain_q == 16'd1) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remain_q    <= '0;
      done_zero_q <= 1'b0;
    end else begin
      done_zero_q <= start_ok && (prog_len == 16'd0);
      if (start_ok) begin
        addr_q   <= base_addr;
        remain_q <= prog_len;
      end else if (in_xfer) begin
        addr_q   <= addr_q + ADDR_W'(4);
        remain_q <= remain_q - 16'd1;
      end
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32 + ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_xfer),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef ENCODER_RANGE_CHECK_EN
  logic range_bad;

  // A value fits a signed field when all bits above the field's sign bit match it.
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:      range_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start_ok) begin
      err <= 1'b0;
    end else if (in_xfer && range_bad) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2: output buffer entries, power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 32: width of the instruction address counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a program load.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: first instruction address, sampled on start.
REQ-007 SHALL have port prog_len, input, 16 bits: instruction count, sampled on start.
REQ-008 SHALL have port in_valid, input, 1 bit: field set is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: encoder accepts a field set.
REQ-010 SHALL have port fmt, input, 3 bits: instruction format; R=0, I=1, S=2, B=3, U=4, J=5.
REQ-011 SHALL have port opcode, input, 7 bits: opcode field.
REQ-012 SHALL have port funct3, input, 3 bits: funct3 field.
REQ-013 SHALL have port funct7, input, 7 bits: funct7 field.
REQ-014 SHALL have ports rd, rs1 and rs2, input, 5 bits each: register indices.
REQ-015 SHALL have port imm, input, 32 bits: immediate value, sign-extended.
REQ-016 SHALL have port out_valid, output, 1 bit: out_inst and out_addr are valid.
REQ-017 SHALL have port out_ready, input, 1 bit: downstream, typically the instruction memory writer, accepts the word.
REQ-018 SHALL have port out_inst, output, 32 bits: encoded instruction word.
REQ-019 SHALL have port out_addr, output, ADDR_W bits: byte address of out_inst.
REQ-020 SHALL have port busy, output, 1 bit: a program load is in progress.
REQ-021 SHALL have port done, output, 1 bit: one-cycle pulse when the last word leaves the encoder.

Function
REQ-022 SHALL implement FSM states IDLE, LOAD and DRAIN; start moves IDLE to LOAD and loads the address and remaining-count registers; start is ignored outside IDLE.
REQ-023 SHALL, when start arrives with prog_len=0, go IDLE to IDLE and pulse done on the next cycle.
REQ-024 SHALL drive in_ready=1 only when in LOAD and the buffer is not full; a transfer occurs when in_valid and in_ready are both high.
REQ-025 SHALL encode each accepted field set in one cycle and write it into the buffer: latency from the input transfer to out_valid is 1 cycle when the buffer is empty.
REQ-026 SHALL use these bit layouts:
- R: funct7, rs2, rs1, funct3, rd, opcode.
- I: imm[11:0], rs1, funct3, rd, opcode.
- S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
- B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
- U: imm[31:12], rd, opcode.
- J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
REQ-027 SHALL encode fmt values 6 and 7 as 32'h00000013, the NOP.
REQ-028 SHALL tag each word with the current address, then advance the address by 4, wrapping modulo 2^ADDR_W.
REQ-029 SHALL decrement the remaining count on each input transfer, and move LOAD to DRAIN when the count reaches 0.
REQ-030 SHALL move DRAIN to IDLE and pulse done in the cycle the final output handshake occurs.
REQ-031 SHALL accept simultaneous buffer push and pop when full, so that full throughput is one word per cycle.
REQ-032 SHALL hold out_inst and out_addr stable while out_valid=1 and out_ready=0.
REQ-033 SHALL drive busy=1 in LOAD and DRAIN.

Reset
REQ-034 SHALL, on rst_n low, immediately set the FSM to IDLE, empty the buffer, and zero the address and count registers.
REQ-035 SHALL reset outputs to in_ready=0, out_valid=0, out_inst=0, out_addr=0, busy=0, done=0 and err=0.
REQ-036 SHALL discard any in-flight words on reset mid-load; no done pulse follows.

Configuration
REQ-037 SHALL, when ENCODER_RANGE_CHECK_EN is defined, add output err: a sticky flag set when an I or S imm lies outside -2048..2047, a B imm is outside the 13-bit range or odd, or a J imm is outside the 21-bit range or odd.
REQ-038 SHALL still encode and emit the word normally when an err condition is detected.
REQ-039 SHALL clear err on start or reset.
REQ-040 SHALL, without ENCODER_RANGE_CHECK_EN, have no err port and no check logic.

Structure
REQ-041 SHALL place the fmt enum, the NOP constant and the opcode constants in shared package riscv_pkg.
REQ-042 SHALL implement the buffer as sub-module inst_fifo, parameterized by DEPTH and a data width of 32+ADDR_W.

Verification
REQ-043 SHALL cover R encode: start with base 0x100 and len 1, then fmt=R, opcode 0x33, funct3 0, funct7 0x20, rd 3, rs1 1, rs2 2 -> out_inst 0x40208 1B3, out_addr 0x100, done pulse.
REQ-044 SHALL cover B encode: fmt=B, opcode 0x63, funct3 0, rs1 1, rs2 2, imm=-8 -> out_inst 0xFE208CE3.
REQ-045 SHALL cover backpressure: len 4 with out_ready=0 -> in_ready falls after DEPTH transfers and the outputs stay stable; release out_ready -> addresses base, +4, +8, +12 in order.
REQ-046 SHALL cover wrap: ADDR_W=8, base 0xFC, len 2 -> out_addr 0xFC then 0x00.
REQ-047 SHALL cover reset mid-load: rst_n low after 2 of 4 transfers -> all outputs 0 immediately; done never pulses.
REQ-048 SHALL cover range check with ENCODER_RANGE_CHECK_EN: fmt=I, imm=4096 -> err=1 and the word is still emitted; the next start clears err.
